// File: rtl/inst_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// master = loader side, slave = UART/memory side.
interface inst_loader_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int WORD_WIDTH = 32
);
  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  byte_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [WORD_WIDTH-1:0] imem_wdata;

  modport master (
    input  byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/inst_loader.sv
// Program loader: header N + N little-endian words from a byte stream into imem; INST_LOADER_CHECKSUM_EN adds an XOR trailer byte.
// One write cycle per word after its 4th byte (byte_ready low then); done/err follow the last write or a failure.
module inst_loader #(
  parameter int ADDR_WIDTH = 14,
  parameter int WORD_WIDTH = 32,
  parameter int TIMEOUT    = 1000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  inst_loader_if.master       bus,
  output logic                cpu_hold,
  output logic                done,
  output logic                err,
  output logic [ADDR_WIDTH:0] word_count
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

`ifdef INST_LOADER_CHECKSUM_EN
  localparam state_t S_FIN = S_CSUM;
`else
  localparam state_t S_FIN = S_DONE;
`endif

  state_t                state_q, state_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [31:0]           hdr_q, hdr_d;
  logic [WORD_WIDTH-1:0] word_q, word_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
  logic [TW-1:0]         tmo_q, tmo_d;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif

  logic        rdy;
  logic        byte_acc;
  logic        last_word;
  logic        oversize;
  logic [31:0] hdr_next;

  assign rdy       = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign byte_acc  = rdy && bus.byte_valid;
  assign hdr_next  = {bus.byte_data, hdr_q[31:8]};
  assign last_word = (33'(word_count_q) + 33'd1) == {1'b0, hdr_q};
  // N equal to the full memory size is legal; only strictly larger is rejected
  assign oversize  = {1'b0, hdr_next} > (33'd1 << ADDR_WIDTH);

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    hdr_d        = hdr_q;
    word_d       = word_q;
    idx_d        = idx_q;
    word_count_d = word_count_q;
    tmo_d        = '0;
`ifdef INST_LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d      = S_HDR;
          byte_cnt_d   = '0;
          hdr_d        = '0;
          idx_d        = '0;
          word_count_d = '0;
`ifdef INST_LOADER_CHECKSUM_EN
          csum_d       = '0;
`endif
        end
      end
      S_HDR: begin
        if (byte_acc) begin
          hdr_d      = hdr_next;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (hdr_next == '0)  state_d = S_FIN;
            else if (oversize)   state_d = S_ERR;
            else                 state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (byte_acc) begin
          word_d     = {bus.byte_data, word_q[WORD_WIDTH-1:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef INST_LOADER_CHECKSUM_EN
          csum_d     = csum_q ^ bus.byte_data;
`endif
          if (byte_cnt_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        word_count_d = word_count_q + (ADDR_WIDTH+1)'(1);
        // the address holds on the last word so a full-memory load ends at all-ones
        if (last_word) begin
          state_d = S_FIN;
        end else begin
          idx_d   = idx_q + ADDR_WIDTH'(1);
          state_d = S_DATA;
        end
      end
`ifdef INST_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (byte_acc) state_d = (bus.byte_data == csum_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (TIMEOUT != 0 && rdy) begin
      if (byte_acc) begin
        tmo_d = '0;
      end else begin
        tmo_d = tmo_q + TW'(1);
        if (32'(tmo_q) + 32'd1 >= 32'(TIMEOUT)) state_d = S_ERR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      byte_cnt_q   <= '0;
      hdr_q        <= '0;
      word_q       <= '0;
      idx_q        <= '0;
      word_count_q <= '0;
      tmo_q        <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      hdr_q        <= hdr_d;
      word_q       <= word_d;
      idx_q        <= idx_d;
      word_count_q <= word_count_d;
      tmo_q        <= tmo_d;
`ifdef INST_LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign bus.byte_ready = rdy;
  assign bus.imem_we    = (state_q == S_WRITE);
  assign bus.imem_addr  = idx_q;
  assign bus.imem_wdata = word_q;
  assign cpu_hold       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done           = (state_q == S_DONE);
  assign err            = (state_q == S_ERR);
  assign word_count     = word_count_q;

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboarded random-load bench for inst_loader (small memory, short timeout).
module tb_inst_loader;
  localparam int AW  = 4;
  localparam int TMO = 16;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic        clk = 0;
  logic        rst_n;
  logic        start;
  logic        cpu_hold, done, err;
  logic [AW:0] word_count;

  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;
  int  last_we_cyc = 0;
  int  end_cyc = 0;
  bit  poke_start = 0;
  wr_t exp_q[$];
  logic [31:0] fixed_w[$];

  inst_loader_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(32)) bus_if ();

  inst_loader #(.ADDR_WIDTH(AW), .WORD_WIDTH(32), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bus        (bus_if),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // write monitor: every strobe must match the next expected (addr, word)
  always @(negedge clk) begin
    wr_t e;
    if (rst_n === 1'b1 && bus_if.imem_we === 1'b1) begin
      last_we_cyc = cyc;
      check("ready_in_write", bus_if.byte_ready, 0);
      if (exp_q.size() == 0) begin
        check("spurious_write", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", bus_if.imem_addr, e.addr);
        check("wr_data", bus_if.imem_wdata, e.data);
      end
    end
  end

  // called at a negedge; returns at the negedge after the byte was consumed
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int guard = 0;
    if (gaps && $urandom_range(0, 2) == 0) begin
      bus_if.byte_valid = 0;
      repeat ($urandom_range(1, 5)) @(negedge clk);
    end
    bus_if.byte_valid = 1;
    bus_if.byte_data  = b;
    if (poke_start && $urandom_range(0, 7) == 0) start = 1;
    while (bus_if.byte_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("byte_accept_timeout", 0, 1);
    @(negedge clk);
    start = 0;
  endtask

  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
    check("start_clears_flags", {done, err}, 0);
    check("hold_on_start", cpu_hold, 1);
  endtask

  task automatic wait_end();
    int g = 0;
    while (!(done === 1'b1 || err === 1'b1) && g < 300) begin
      @(negedge clk);
      g++;
    end
    end_cyc = cyc;
    if (g >= 300) check("end_timeout", 0, 1);
  endtask

  task automatic do_load(input logic [31:0] n, input bit gaps, input logic [7:0] csum_flip);
    logic [31:0] w;
    logic [7:0]  x = 8'h00;
    bit          exp_err;
    int          nw;
    exp_err = (n > (1 << AW));
    nw      = exp_err ? 0 : int'(n);
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], gaps);
    for (int i = 0; i < nw; i++) begin
      w = (i < fixed_w.size()) ? fixed_w[i] : $urandom;
      exp_q.push_back('{addr: AW'(i), data: w});
      for (int b = 0; b < 4; b++) begin
        send_byte(w[8*b +: 8], gaps);
        x ^= w[8*b +: 8];
      end
    end
`ifdef INST_LOADER_CHECKSUM_EN
    if (!exp_err) begin
      send_byte(x ^ csum_flip, gaps);
      if (csum_flip != 0) exp_err = 1;
    end
`else
    if (csum_flip != 0 || x == 8'h00) x = 8'h00;
`endif
    bus_if.byte_valid = 0;
    wait_end();
    check("done", done, !exp_err);
    check("err", err, exp_err);
    check("cpu_hold", cpu_hold, exp_err);
    check("word_count", word_count, nw);
    check("pending_writes", exp_q.size(), 0);
`ifndef INST_LOADER_CHECKSUM_EN
    if (nw > 0 && !exp_err) check("done_latency", end_cyc, last_we_cyc + 1);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] w0, w1;
    rst_n = 0;
    start = 1;
    bus_if.byte_valid = 0;
    bus_if.byte_data  = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_byte_ready", bus_if.byte_ready, 0);
    check("rst_imem_we", bus_if.imem_we, 0);
    check("rst_imem_addr", bus_if.imem_addr, 0);
    check("rst_imem_wdata", bus_if.imem_wdata, 0);
    check("rst_cpu_hold", cpu_hold, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_word_count", word_count, 0);
    rst_n = 1;
    start = 0;
    @(negedge clk);

    // basic two-word program, continuous stream
    fixed_w = {32'h00000513, 32'h00100593};
    do_load(2, 0, 8'h00);
    fixed_w = {};

    do_load(0, 0, 8'h00);
    do_load((1 << AW) + 1, 0, 8'h00);

    // full-capacity load: address must finish at all-ones
    do_load(1 << AW, 0, 8'h00);
    check("full_last_addr", bus_if.imem_addr, (1 << AW) - 1);

    for (int k = 0; k < 6; k++) begin
      poke_start = (k % 2 == 1);
      do_load($urandom_range(1, 1 << AW), 1, 8'h00);
    end
    poke_start = 0;

    // idle timeout mid-word
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte((i == 0) ? 8'h02 : 8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    bus_if.byte_valid = 0;
    repeat (TMO - 1) @(negedge clk);
    check("tmo_not_early", err, 0);
    @(negedge clk);
    check("tmo_err", err, 1);
    check("tmo_hold", cpu_hold, 1);

    // reset after six data bytes, then a clean one-word load
    w0 = $urandom;
    w1 = $urandom;
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte((i == 0) ? 8'h02 : 8'h00, 0);
    exp_q.push_back('{addr: AW'(0), data: w0});
    for (int b = 0; b < 4; b++) send_byte(w0[8*b +: 8], 0);
    for (int b = 0; b < 2; b++) send_byte(w1[8*b +: 8], 0);
    bus_if.byte_valid = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    check("midrst_hold", cpu_hold, 0);
    check("midrst_ready", bus_if.byte_ready, 0);
    check("midrst_flags", {done, err}, 0);
    check("midrst_count", word_count, 0);
    check("midrst_addr", bus_if.imem_addr, 0);
    check("midrst_pending", exp_q.size(), 0);
    rst_n = 1;
    @(negedge clk);
    do_load(1, 0, 8'h00);

`ifdef INST_LOADER_CHECKSUM_EN
    fixed_w = {32'h00000513};
    do_load(1, 0, 8'h00);
    do_load(1, 0, 8'h01);
    fixed_w = {};
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Writer side of the instruction-memory interface.
- Takes a byte stream from the UART receiver, assembles little-endian 32-bit instruction words, and writes them into instruction memory at consecutive word addresses.
- Holds the CPU (cpu_hold) while a program is loading, then releases it so the fetch/decode path reads the new image from word address 0.

Parameters:
- ADDR_WIDTH, 14, instruction-memory word-address width; capacity = 2^ADDR_WIDTH words.
- WORD_WIDTH, 32, instruction word width; fixed at 32 (= `REGWIDTH).
- TIMEOUT, 1000000, maximum idle cycles between accepted bytes while loading; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse that begins a load
- byte_valid  in  1  byte_data holds a valid byte
- byte_data  in  8  received byte
- byte_ready  out  1  loader can accept a byte this cycle
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  ADDR_WIDTH  word address to write
- imem_wdata  out  WORD_WIDTH  word to write
- cpu_hold  out  1  stall/reset request to the CPU
- done  out  1  load completed successfully (level)
- err  out  1  load aborted (level)
- word_count  out  ADDR_WIDTH+1  words written in the current/last load

Behaviour:
- Clock and reset:
  - Single clock.
  - Reset is synchronous, active-low, sampled on the rising clk edge.
- Reset values:
  - State IDLE.
  - byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=0, done=0, err=0, word_count=0.
  - Internal byte counter, word index, header register and timeout counter all 0.
- Handshake:
  - A byte is consumed on a cycle where byte_valid & byte_ready.
  - byte_ready=1 only in HDR and DATA (and CSUM when enabled).
- Stream format:
  - 4-byte header N (little-endian, byte 0 = bits 7:0), then N words of 4 bytes each, little-endian.
- States:
  - IDLE: start -> HDR, cpu_hold=1, word_count=0. All other inputs ignored.
  - HDR: collect 4 bytes into N.
    - On the 4th byte, if N == 0 -> DONE.
    - If N > 2^ADDR_WIDTH -> ERR.
    - Otherwise -> DATA.
  - DATA: collect 4 bytes into a word shift register. On the 4th byte -> WRITE.
  - WRITE: one cycle.
    - imem_we=1, imem_addr=index, imem_wdata=assembled word; byte_ready=0.
    - Next cycle: index+1, word_count+1.
    - Last word (index == N-1) -> DONE (or CSUM); otherwise -> DATA.
  - DONE: done=1, cpu_hold=0. start -> HDR (clears done, word_count, index).
  - ERR: err=1, cpu_hold=1. start -> HDR (clears err). Words already written stay in memory.
- Latency:
  - WRITE is entered the cycle after the 4th byte is accepted.
  - The memory write occurs in that cycle: one-cycle write per word, with no byte accepted during it.
  - done rises the cycle after the last WRITE.
- Timeout (TIMEOUT != 0):
  - The counter runs in HDR, DATA and CSUM and clears on each accepted byte.
  - Reaching TIMEOUT -> ERR.
- Boundaries:
  - start while in HDR/DATA/WRITE/CSUM is ignored.
  - N = 2^ADDR_WIDTH is legal; imem_addr ends at all-ones with no wrap.
  - Reset mid-load returns to IDLE with all outputs at reset values; partial memory contents are not undone.
  - byte_valid held high across WRITE is not consumed until DATA.

Optional Feature:
- Macro: INST_LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR of all data bytes (not header bytes) is kept.
  - After the last WRITE -> CSUM state, which accepts one trailer byte.
  - Trailer equal to the XOR -> DONE; mismatch -> ERR.
  - For N == 0 the expected checksum is 0x00, so the header goes to CSUM rather than DONE.
- Not defined:
  - No CSUM state and no trailer byte; behaviour exactly as described above.

Test Plan:
- Reset: rst_n=0 for 2 cycles with start=1 -> all outputs 0, state IDLE, byte_ready=0.
- Basic load: start; bytes 02 00 00 00, 13 05 00 00, 93 05 10 00 -> writes addr0=0x00000513, addr1=0x00100593; word_count=2; done=1; cpu_hold=0. Without checksum, done=1 one cycle after the second imem_we.
- Empty and oversize headers:
  - Header 00 00 00 00 -> DONE with no imem_we (without checksum).
  - Header with N = 2^ADDR_WIDTH+1 -> err=1, cpu_hold=1, no writes.
- Backpressure and timeout:
  - byte_valid held continuously -> no byte consumed in the WRITE cycle; byte order preserved.
  - With TIMEOUT=16, stall 16 cycles mid-word -> err=1.
- Reset mid-load: rst_n=0 after 6 data bytes -> IDLE, cpu_hold=0; a subsequent full load of N=1 writes addr0 correctly.
- Checksum (INST_LOADER_CHECKSUM_EN): N=1, word 0x00000513 -> trailer 0x16 gives done=1; trailer 0x17 gives err=1.
